// File: rtl/eth_tx_arbiter_if.sv
// AXI4-Stream style 32-bit beat channel shared by the arbiter's source and MAC ports.
interface eth_tx_arbiter_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    // Stream producer: drives payload and valid, observes ready.
    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    // Stream consumer: observes payload and valid, drives ready.
    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-granular arbiter merging the ARP-reply and UDP/IP streams onto MAC TX.
// The data path is a zero-latency combinational mux; a grant is held until the
// source's tlast. Frames reaching MAX_BEATS get a forced tlast, and the rest of
// the offending source frame is drained and discarded.
module eth_tx_arbiter #(
    parameter int unsigned PRIORITY_MODE = 0,
    parameter int unsigned MAX_BEATS     = 380
) (
    input  logic                    tx_mac_aclk,
    input  logic                    tx_mac_reset,
    eth_tx_arbiter_if.slave         tx_axis_arp,
    eth_tx_arbiter_if.slave         tx_axis_udp,
    eth_tx_arbiter_if.master        tx_axis_mac,
    output logic                    busy,
    output logic                    err_overlong,
    input  logic                    clr_err,
    output logic [15:0]             arp_frame_cnt,
    output logic [15:0]             udp_frame_cnt
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEAT_W = 11;
    localparam int unsigned CNT_W  = 16;
    localparam logic [BEAT_W-1:0] LAST_BEAT_IDX = BEAT_W'(MAX_BEATS - 1);
    localparam bit ARP_FIRST = (PRIORITY_MODE == 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_ARP = 2'd1,
        GNT_UDP = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    typedef enum logic {
        SRC_ARP = 1'b0,
        SRC_UDP = 1'b1
    } src_e;

    state_e              state_q, state_d;
    src_e                last_grant_q, last_grant_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    arp_cnt_q, arp_cnt_d;
    logic [CNT_W-1:0]    udp_cnt_q, udp_cnt_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    // Selected source view; last_grant always names the source owning GNT_x/DRAIN.
    logic [DATA_W-1:0]   src_tdata_c;
    logic                src_tvalid_c;
    logic                src_tlast_c;
    logic                at_limit_c;

    logic [DATA_W-1:0]   mac_tdata_c;
    logic                mac_tvalid_c;
    logic                mac_tlast_c;
    logic                arp_tready_c;
    logic                udp_tready_c;

    // Source selection follows the current grant owner.
    always_comb begin
        src_tdata_c  = tx_axis_arp.tdata;
        src_tvalid_c = tx_axis_arp.tvalid;
        src_tlast_c  = tx_axis_arp.tlast;
        if (last_grant_q == SRC_UDP) begin
            src_tdata_c  = tx_axis_udp.tdata;
            src_tvalid_c = tx_axis_udp.tvalid;
            src_tlast_c  = tx_axis_udp.tlast;
        end
        at_limit_c = (beat_cnt_q == LAST_BEAT_IDX);
    end

    // Next-state, counters and combinational stream mux.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        arp_cnt_d    = arp_cnt_q;
        udp_cnt_d    = udp_cnt_q;
        err_d        = clr_err ? 1'b0 : err_q;
        mac_tdata_c  = '0;
        mac_tvalid_c = 1'b0;
        mac_tlast_c  = 1'b0;
        arp_tready_c = 1'b0;
        udp_tready_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Ties go to ARP in fixed mode, otherwise to the source not served last.
                if (tx_axis_arp.tvalid &&
                    (!tx_axis_udp.tvalid || ARP_FIRST || last_grant_q == SRC_UDP)) begin
                    state_d      = GNT_ARP;
                    last_grant_d = SRC_ARP;
                end else if (tx_axis_udp.tvalid) begin
                    state_d      = GNT_UDP;
                    last_grant_d = SRC_UDP;
                end
            end

            GNT_ARP, GNT_UDP: begin
                mac_tdata_c  = src_tdata_c;
                mac_tvalid_c = src_tvalid_c;
                mac_tlast_c  = src_tlast_c | at_limit_c;
                if (last_grant_q == SRC_UDP) begin
                    udp_tready_c = tx_axis_mac.tready;
                end else begin
                    arp_tready_c = tx_axis_mac.tready;
                end

                if (src_tvalid_c && tx_axis_mac.tready) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (at_limit_c && !src_tlast_c) begin
                        err_d   = 1'b1;
                        state_d = DRAIN;
                    end else if (src_tlast_c) begin
                        if (last_grant_q == SRC_UDP) begin
                            udp_cnt_d = udp_cnt_q + CNT_W'(1);
                        end else begin
                            arp_cnt_d = arp_cnt_q + CNT_W'(1);
                        end
                        state_d = IDLE;
                    end
                end
            end

            DRAIN: begin
                // Swallow the remainder of the truncated frame without touching the MAC.
                if (last_grant_q == SRC_UDP) begin
                    udp_tready_c = 1'b1;
                end else begin
                    arp_tready_c = 1'b1;
                end
                if (src_tvalid_c && src_tlast_c) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            beat_cnt_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and status registers with synchronous active-high reset.
    always_ff @(posedge tx_mac_aclk) begin
        if (tx_mac_reset) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_UDP;
            beat_cnt_q   <= '0;
            arp_cnt_q    <= '0;
            udp_cnt_q    <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            arp_cnt_q    <= arp_cnt_d;
            udp_cnt_q    <= udp_cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_axis_mac.tdata  = mac_tdata_c;
    assign tx_axis_mac.tvalid = mac_tvalid_c;
    assign tx_axis_mac.tlast  = mac_tlast_c;
    assign tx_axis_arp.tready = arp_tready_c;
    assign tx_axis_udp.tready = udp_tready_c;

    assign busy          = busy_q;
    assign err_overlong  = err_q;
    assign arp_frame_cnt = arp_cnt_q;
    assign udp_frame_cnt = udp_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: dut0 is round-robin, dut1 is fixed ARP-first.
// Sources are queue-fed stream drivers; the MAC side is a monitor capturing beats.
module tb_eth_tx_arbiter;
    localparam int unsigned NDUT = 2;
    localparam int unsigned NSRC = 4;
    localparam int unsigned MAXB = 380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run    = 0;
    int tests_failed = 0;

    eth_tx_arbiter_if src_if [NSRC] ();
    eth_tx_arbiter_if mac_if [NDUT] ();

    logic        rst     [NDUT];
    logic        clr_err [NDUT];
    logic        busy    [NDUT];
    logic        err     [NDUT];
    logic [15:0] arp_cnt [NDUT];
    logic [15:0] udp_cnt [NDUT];

    eth_tx_arbiter #(.PRIORITY_MODE(0), .MAX_BEATS(MAXB)) dut0 (
        .tx_mac_aclk  (clk),
        .tx_mac_reset (rst[0]),
        .tx_axis_arp  (src_if[0]),
        .tx_axis_udp  (src_if[1]),
        .tx_axis_mac  (mac_if[0]),
        .busy         (busy[0]),
        .err_overlong (err[0]),
        .clr_err      (clr_err[0]),
        .arp_frame_cnt(arp_cnt[0]),
        .udp_frame_cnt(udp_cnt[0])
    );

    eth_tx_arbiter #(.PRIORITY_MODE(1), .MAX_BEATS(MAXB)) dut1 (
        .tx_mac_aclk  (clk),
        .tx_mac_reset (rst[1]),
        .tx_axis_arp  (src_if[2]),
        .tx_axis_udp  (src_if[3]),
        .tx_axis_mac  (mac_if[1]),
        .busy         (busy[1]),
        .err_overlong (err[1]),
        .clr_err      (clr_err[1]),
        .arp_frame_cnt(arp_cnt[1]),
        .udp_frame_cnt(udp_cnt[1])
    );

    // Per-source beat queues ({tlast, tdata}) and stimulus knobs.
    logic [32:0]  src_q [NSRC][$];
    int unsigned  gap_pct [NSRC]     = '{0, 0, 0, 0};
    int unsigned  mac_rdy_pct [NDUT] = '{100, 100};

    logic         s_tready [NSRC];
    logic         s_tvalid [NSRC];
    logic         m_tvalid [NDUT];
    logic         m_tlast  [NDUT];

    logic [32:0]  mac_q   [NDUT][$];
    int           mac_cyc [NDUT][$];
    int           udp_rdy_seen [NDUT];

    // Source drivers: hold a beat once offered, advance on a completed handshake.
    for (genvar g = 0; g < NSRC; g++) begin : g_src
        bit xfer;
        assign s_tready[g] = src_if[g].tready;
        assign s_tvalid[g] = src_if[g].tvalid;
        always @(negedge clk) xfer = (src_if[g].tvalid === 1'b1) && (src_if[g].tready === 1'b1);
        always @(posedge clk) begin
            #1;
            if (xfer && src_q[g].size() > 0) void'(src_q[g].pop_front());
            if (src_q[g].size() == 0) begin
                src_if[g].tvalid = 1'b0;
            end else if (!(src_if[g].tvalid === 1'b1 && !xfer)) begin
                src_if[g].tvalid = ($urandom_range(99) >= gap_pct[g]);
            end
            if (src_q[g].size() > 0) begin
                src_if[g].tlast = src_q[g][0][32];
                src_if[g].tdata = src_q[g][0][31:0];
            end else begin
                src_if[g].tlast = 1'b0;
                src_if[g].tdata = 32'h0;
            end
        end
    end

    // MAC side: random ready and capture of every accepted beat.
    for (genvar d = 0; d < NDUT; d++) begin : g_mac
        assign m_tvalid[d] = mac_if[d].tvalid;
        assign m_tlast[d]  = mac_if[d].tlast;
        always @(posedge clk) begin
            #1;
            mac_if[d].tready = ($urandom_range(99) < mac_rdy_pct[d]);
        end
        always @(negedge clk) begin
            if (mac_if[d].tvalid === 1'b1 && mac_if[d].tready === 1'b1) begin
                mac_q[d].push_back({mac_if[d].tlast, mac_if[d].tdata});
                mac_cyc[d].push_back(cyc);
            end
            if (src_if[2*d+1].tready === 1'b1) udp_rdy_seen[d] = udp_rdy_seen[d] + 1;
        end
    end

    // Beat tag: {tlast, src, frame id, beat index}.
    function automatic logic [32:0] mk_beat(input int src, input int fid, input int b, input int len);
        return {1'(b == len - 1), 1'(src), 15'(fid), 16'(b)};
    endfunction

    function automatic void push_frame(input int q, input int src, input int fid, input int len);
        for (int b = 0; b < len; b++) src_q[q].push_back(mk_beat(src, fid, b, len));
    endfunction

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d]     = 1'b1;
        clr_err[d] = 1'b0;
        repeat (3) @(negedge clk);
        rst[d] = 1'b0;
        @(negedge clk);
        mac_q[d].delete();
        mac_cyc[d].delete();
        udp_rdy_seen[d] = 0;
    endtask

    task automatic wait_idle(input int d, input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (src_q[2*d].size() == 0 && src_q[2*d+1].size() == 0 &&
                busy[d] === 1'b0 && m_tvalid[d] === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            outs = {busy[d], s_tready[2*d], s_tready[2*d+1], m_tvalid[d], m_tlast[d], err[d]};
            tests_run++;
            if (outs !== 6'b0) begin
                tests_failed++;
                $display("FAIL reset_outputs dut%0d got=%b exp=000000", d, outs);
            end
            tests_run++;
            if ({arp_cnt[d], udp_cnt[d]} !== 32'h0) begin
                tests_failed++;
                $display("FAIL reset_counters dut%0d got=%h exp=00000000", d, {arp_cnt[d], udp_cnt[d]});
            end
            rst[d] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_single_arp();
        bit          to;
        int          rise;
        logic [32:0] got;
        do_reset(0);
        mac_rdy_pct[0] = 100;
        gap_pct[0]     = 0;
        rise           = -1;
        push_frame(0, 0, 1, 11);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_tvalid[0] === 1'b1) begin
                rise = cyc;
                break;
            end
        end
        wait_idle(0, 200, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL single_arp_timeout got=timeout exp=idle");
        end
        tests_run++;
        if (mac_q[0].size() != 11) begin
            tests_failed++;
            $display("FAIL single_arp_len got=%0d exp=11", mac_q[0].size());
        end
        for (int b = 0; b < 11; b++) begin
            got = (b < mac_q[0].size()) ? mac_q[0][b] : 33'bx;
            tests_run++;
            if (got !== mk_beat(0, 1, b, 11)) begin
                tests_failed++;
                $display("FAIL single_arp_beat%0d got=%h exp=%h", b, got, mk_beat(0, 1, b, 11));
            end
        end
        tests_run++;
        if (mac_cyc[0].size() == 0 || mac_cyc[0][0] != rise + 1) begin
            tests_failed++;
            $display("FAIL single_arp_latency got=%0d exp=%0d",
                     (mac_cyc[0].size() == 0) ? -1 : mac_cyc[0][0], rise + 1);
        end
        tests_run++;
        if (arp_cnt[0] !== 16'd1 || udp_cnt[0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL single_arp_cnt got=%0d/%0d exp=1/0", arp_cnt[0], udp_cnt[0]);
        end
        tests_run++;
        if (udp_rdy_seen[0] != 0) begin
            tests_failed++;
            $display("FAIL single_arp_udp_tready got=%0d exp=0", udp_rdy_seen[0]);
        end
    endtask

    task automatic test_arbitration(input int d);
        bit          to;
        int          la [3];
        int          lu [3];
        int          ai, ui, gap_exp;
        bit          last_udp, pick_arp;
        logic [32:0] exp_q [$];
        logic [32:0] got;
        do_reset(d);
        mac_rdy_pct[d]  = 100;
        gap_pct[2*d]    = 0;
        gap_pct[2*d+1]  = 0;
        for (int i = 0; i < 3; i++) begin
            la[i] = $urandom_range(1, 12);
            lu[i] = $urandom_range(1, 12);
            push_frame(2*d,   0, 10 + i, la[i]);
            push_frame(2*d+1, 1, 20 + i, lu[i]);
        end
        // Expected frame order: fixed mode drains ARP first; round-robin alternates from ARP.
        ai = 0; ui = 0; last_udp = 1'b1;
        while (ai < 3 || ui < 3) begin
            pick_arp = (ai < 3) && (ui >= 3 || d == 1 || last_udp);
            if (pick_arp) begin
                for (int b = 0; b < la[ai]; b++) exp_q.push_back(mk_beat(0, 10 + ai, b, la[ai]));
                ai++;
            end else begin
                for (int b = 0; b < lu[ui]; b++) exp_q.push_back(mk_beat(1, 20 + ui, b, lu[ui]));
                ui++;
            end
            last_udp = !pick_arp;
        end
        wait_idle(d, 600, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL arb%0d_timeout got=timeout exp=idle", d);
        end
        tests_run++;
        if (mac_q[d].size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL arb%0d_len got=%0d exp=%0d", d, mac_q[d].size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < mac_q[d].size()) ? mac_q[d][i] : 33'bx;
            tests_run++;
            if (got !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL arb%0d_beat%0d got=%h exp=%h", d, i, got, exp_q[i]);
            end
            if (i > 0 && i < mac_cyc[d].size()) begin
                gap_exp = exp_q[i-1][32] ? 2 : 1;
                tests_run++;
                if (mac_cyc[d][i] - mac_cyc[d][i-1] != gap_exp) begin
                    tests_failed++;
                    $display("FAIL arb%0d_spacing%0d got=%0d exp=%0d", d, i,
                             mac_cyc[d][i] - mac_cyc[d][i-1], gap_exp);
                end
            end
        end
        tests_run++;
        if (arp_cnt[d] !== 16'd3 || udp_cnt[d] !== 16'd3) begin
            tests_failed++;
            $display("FAIL arb%0d_cnt got=%0d/%0d exp=3/3", d, arp_cnt[d], udp_cnt[d]);
        end
    endtask

    task automatic test_random();
        bit          to;
        int          len, cur, src;
        logic [32:0] exp_a [$];
        logic [32:0] exp_u [$];
        logic [32:0] got, e;
        do_reset(0);
        mac_rdy_pct[0] = 50;
        gap_pct[0]     = 30;
        gap_pct[1]     = 30;
        for (int f = 0; f < 8; f++) begin
            len = $urandom_range(1, 24);
            push_frame(0, 0, 100 + f, len);
            for (int b = 0; b < len; b++) exp_a.push_back(mk_beat(0, 100 + f, b, len));
            len = $urandom_range(1, 24);
            push_frame(1, 1, 200 + f, len);
            for (int b = 0; b < len; b++) exp_u.push_back(mk_beat(1, 200 + f, b, len));
        end
        wait_idle(0, 5000, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL random_timeout got=timeout exp=idle");
        end
        cur = -1;
        for (int i = 0; i < mac_q[0].size(); i++) begin
            got = mac_q[0][i];
            src = int'(got[31]);
            e   = 33'bx;
            if (src == 0 && exp_a.size() > 0) e = exp_a.pop_front();
            if (src == 1 && exp_u.size() > 0) e = exp_u.pop_front();
            tests_run++;
            if (got !== e || (cur >= 0 && cur != src)) begin
                tests_failed++;
                $display("FAIL random_beat%0d got=%h exp=%h owner=%0d", i, got, e, cur);
            end
            cur = got[32] ? -1 : src;
        end
        tests_run++;
        if (exp_a.size() + exp_u.size() != 0) begin
            tests_failed++;
            $display("FAIL random_missing got=%0d exp=0", exp_a.size() + exp_u.size());
        end
        tests_run++;
        if (arp_cnt[0] !== 16'd8 || udp_cnt[0] !== 16'd8) begin
            tests_failed++;
            $display("FAIL random_cnt got=%0d/%0d exp=8/8", arp_cnt[0], udp_cnt[0]);
        end
        gap_pct[0]     = 0;
        gap_pct[1]     = 0;
        mac_rdy_pct[0] = 100;
    endtask

    task automatic test_overlong();
        bit          to;
        logic [32:0] got, e;
        do_reset(0);
        mac_rdy_pct[0] = 100;
        push_frame(1, 1, 5, 400);
        wait_idle(0, 1500, to);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL overlong_timeout got=timeout exp=idle");
        end
        tests_run++;
        if (mac_q[0].size() != MAXB) begin
            tests_failed++;
            $display("FAIL overlong_len got=%0d exp=%0d", mac_q[0].size(), MAXB);
        end
        for (int b = 0; b < int'(MAXB); b++) begin
            got = (b < mac_q[0].size()) ? mac_q[0][b] : 33'bx;
            e   = mk_beat(1, 5, b, 400);
            if (b == int'(MAXB) - 1) e[32] = 1'b1;
            tests_run++;
            if (got !== e) begin
                tests_failed++;
                $display("FAIL overlong_beat%0d got=%h exp=%h", b, got, e);
            end
        end
        tests_run++;
        if (err[0] !== 1'b1 || udp_cnt[0] !== 16'd0 || arp_cnt[0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL overlong_status got=err%b udp%0d arp%0d exp=err1 udp0 arp0",
                     err[0], udp_cnt[0], arp_cnt[0]);
        end
        clr_err[0] = 1'b1;
        @(negedge clk);
        clr_err[0] = 1'b0;
        tests_run++;
        if (err[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL overlong_clr got=%b exp=0", err[0]);
        end
        // A frame of exactly MAX_BEATS beats is legal.
        mac_q[0].delete();
        mac_cyc[0].delete();
        push_frame(0, 0, 6, MAXB);
        wait_idle(0, 1500, to);
        tests_run++;
        if (to || mac_q[0].size() != MAXB) begin
            tests_failed++;
            $display("FAIL exact_len got=%0d exp=%0d", mac_q[0].size(), MAXB);
        end
        got = (mac_q[0].size() > 0) ? mac_q[0][mac_q[0].size() - 1] : 33'bx;
        tests_run++;
        if (got !== mk_beat(0, 6, MAXB - 1, MAXB)) begin
            tests_failed++;
            $display("FAIL exact_last got=%h exp=%h", got, mk_beat(0, 6, MAXB - 1, MAXB));
        end
        tests_run++;
        if (err[0] !== 1'b0 || arp_cnt[0] !== 16'd1) begin
            tests_failed++;
            $display("FAIL exact_status got=err%b arp%0d exp=err0 arp1", err[0], arp_cnt[0]);
        end
    endtask

    task automatic test_reset_midframe();
        bit          to;
        logic [4:0]  outs;
        logic [32:0] got;
        do_reset(0);
        mac_rdy_pct[0] = 100;
        push_frame(1, 1, 7, 20);
        to = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mac_q[0].size() >= 4) begin
                to = 1'b0;
                break;
            end
        end
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL rst_mid_start got=timeout exp=4beats");
        end
        rst[0] = 1'b1;
        @(negedge clk);
        outs = {s_tready[0], s_tready[1], m_tvalid[0], m_tlast[0], busy[0]};
        tests_run++;
        if (outs !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_outputs got=%b exp=00000", outs);
        end
        tests_run++;
        if ({arp_cnt[0], udp_cnt[0], err[0]} !== 33'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_status got=%0d/%0d/%b exp=0/0/0", arp_cnt[0], udp_cnt[0], err[0]);
        end
        src_q[1].delete();
        @(negedge clk);
        rst[0] = 1'b0;
        repeat (2) @(negedge clk);
        mac_q[0].delete();
        mac_cyc[0].delete();
        push_frame(0, 0, 8, 6);
        wait_idle(0, 200, to);
        tests_run++;
        if (to || mac_q[0].size() != 6) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh_len got=%0d exp=6", mac_q[0].size());
        end
        for (int b = 0; b < 6; b++) begin
            got = (b < mac_q[0].size()) ? mac_q[0][b] : 33'bx;
            tests_run++;
            if (got !== mk_beat(0, 8, b, 6)) begin
                tests_failed++;
                $display("FAIL rst_mid_fresh_beat%0d got=%h exp=%h", b, got, mk_beat(0, 8, b, 6));
            end
        end
        tests_run++;
        if (arp_cnt[0] !== 16'd1 || udp_cnt[0] !== 16'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_fresh_cnt got=%0d/%0d exp=1/0", arp_cnt[0], udp_cnt[0]);
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            rst[d]          = 1'b1;
            clr_err[d]      = 1'b0;
            udp_rdy_seen[d] = 0;
        end
        test_reset();
        test_single_arp();
        test_arbitration(0);
        test_arbitration(1);
        test_random();
        test_overlong();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
